// File: rtl/track_pkg.sv
// Shared constants and types for the two-train track plant model.
// Route codes, drive encodings, train state encoding and sensor bit positions.
package track_pkg;

   localparam logic [2:0] ROUTE_A  = 3'b000;
   localparam logic [2:0] ROUTE_B  = 3'b011;

   localparam logic [1:0] DIR_FWD  = 2'b01;
   localparam logic [1:0] DIR_STOP = 2'b00;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FAULT = 2'd2
   } train_state_e;

   localparam int SR_A_APPR = 1;
   localparam int SR_B_APPR = 2;
   localparam int SR_A_EXIT = 3;
   localparam int SR_B_EXIT = 4;

   function automatic logic in_common(input int pos, input int lo, input int hi);
      return (pos >= lo) && (pos <= hi);
   endfunction

endpackage

// File: rtl/train_pos.sv
// One train on its own circular loop: position, RUN/HOLD/FAULT state,
// route check against the shared segment and the approach/exit sensor pair.
module train_pos
   import track_pkg::*;
#(
   parameter int         LOOP_LEN  = 16,
   parameter int         COM_START = 4,
   parameter int         COM_END   = 7,
   parameter logic [2:0] ROUTE     = ROUTE_A,
   parameter int         INIT      = 0,
   localparam int        PW        = $clog2(LOOP_LEN)
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          tick_i,
   input  logic [2:0]    sw_i,
   input  logic [1:0]    dir_i,
   input  logic          force_fault_i,
   output logic [PW-1:0] pos_o,
   output logic [PW-1:0] pos_next_o,
   output logic          derail_o,
   output logic          approach_o,
   output logic          exit_o
);

   logic [PW-1:0] pos_q, pos_d, cand;
   train_state_e  state_q, state_d;
   logic          derail_q, derail_d, derail_now;

   always_comb begin
      cand = pos_q;
      if (dir_i == DIR_FWD)
         cand = (pos_q == PW'(LOOP_LEN-1)) ? '0 : pos_q + 1'b1;

      // A stopped train inside the segment is checked too, since cand == pos_q.
      derail_now = (state_q != ST_FAULT) && in_common(int'(cand), COM_START, COM_END)
                   && (sw_i != ROUTE);

      pos_d    = pos_q;
      state_d  = state_q;
      derail_d = derail_q;
      if (state_q != ST_FAULT) begin
         if (derail_now) begin
            state_d  = ST_FAULT;
            derail_d = 1'b1;
         end else begin
            pos_d   = cand;
            state_d = (dir_i == DIR_FWD) ? ST_RUN : ST_HOLD;
         end
      end
      if (force_fault_i)
         state_d = ST_FAULT;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pos_q    <= PW'(INIT);
         state_q  <= ST_RUN;
         derail_q <= 1'b0;
      end else if (tick_i) begin
         pos_q    <= pos_d;
         state_q  <= state_d;
         derail_q <= derail_d;
      end
   end

   assign pos_o      = pos_q;
   assign pos_next_o = pos_d;
   assign derail_o   = derail_q;
   assign approach_o = (pos_q == PW'(COM_START-1));
   assign exit_o     = (pos_q == PW'(COM_END+1));

endmodule

// File: rtl/track_plant.sv
// Two-train track plant: movement prescaler, both trains, collision detection
// on the shared segment and sensor vector assembly.
module track_plant
   import track_pkg::*;
#(
   parameter int  LOOP_LEN  = 16,
   parameter int  COM_START = 4,
   parameter int  COM_END   = 7,
   parameter int  STEP_DIV  = 4,
   parameter int  A_INIT    = 0,
   parameter int  B_INIT    = 8,
   localparam int PW        = $clog2(LOOP_LEN)
) (
   input  logic          Clock,
   input  logic          RESET_N,
   input  logic [3:1]    SW,
   input  logic [1:0]    DA,
   input  logic [1:0]    DB,
   output logic [4:1]    SR,
   output logic [PW-1:0] POS_A,
   output logic [PW-1:0] POS_B,
   output logic [1:0]    DERAIL,
   output logic          CRASH
);

   localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick;
   logic          crash_q, crash_now;
   logic [PW-1:0] pos_next_a, pos_next_b;
   logic          appr_a, appr_b, exit_a, exit_b;

   assign tick  = (cnt_q == CW'(STEP_DIV-1));
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   // Collision uses post-update positions; a derailed train keeps its old one.
   assign crash_now = tick && in_common(int'(pos_next_a), COM_START, COM_END)
                           && in_common(int'(pos_next_b), COM_START, COM_END);

   always_ff @(posedge Clock or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q   <= '0;
         crash_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         crash_q <= crash_q | crash_now;
      end
   end

   train_pos #(
      .LOOP_LEN (LOOP_LEN), .COM_START(COM_START), .COM_END(COM_END),
      .ROUTE    (ROUTE_A),  .INIT     (A_INIT)
   ) u_train_a (
      .clk_i(Clock), .rst_n_i(RESET_N), .tick_i(tick), .sw_i(SW), .dir_i(DA),
      .force_fault_i(crash_now), .pos_o(POS_A), .pos_next_o(pos_next_a),
      .derail_o(DERAIL[0]), .approach_o(appr_a), .exit_o(exit_a)
   );

   train_pos #(
      .LOOP_LEN (LOOP_LEN), .COM_START(COM_START), .COM_END(COM_END),
      .ROUTE    (ROUTE_B),  .INIT     (B_INIT)
   ) u_train_b (
      .clk_i(Clock), .rst_n_i(RESET_N), .tick_i(tick), .sw_i(SW), .dir_i(DB),
      .force_fault_i(crash_now), .pos_o(POS_B), .pos_next_o(pos_next_b),
      .derail_o(DERAIL[1]), .approach_o(appr_b), .exit_o(exit_b)
   );

   always_comb begin
      SR            = '0;
      SR[SR_A_APPR] = appr_a;
      SR[SR_B_APPR] = appr_b;
      SR[SR_A_EXIT] = exit_a;
      SR[SR_B_EXIT] = exit_b;
   end

   assign CRASH = crash_q;

endmodule

// File: doc/track_plant.md
# track_plant

Synthesizable model of the two-train track that the train controller FSM drives. It consumes the controller's switch and direction outputs (SW, DA, DB) and produces the sensor vector SR[4:1], closing the loop in simulation and on the FPGA demo. Each train has a position on its own circular loop. A shared common segment is checked for wrong switch routing and for collisions.

## Interface
Parameters:
- LOOP_LEN, 16: positions per loop; position width is clog2(LOOP_LEN).
- COM_START, 4: first position of the common segment on both loops.
- COM_END, 7: last position of the common segment. Requires COM_START ≥ 1 and COM_END ≤ LOOP_LEN-2.
- STEP_DIV, 4: clocks per movement tick. Must be ≥ 1.
- A_INIT, 0: train A position at reset.
- B_INIT, 8: train B position at reset.

Ports:
- Clock, input, 1: system clock, rising edge.
- RESET_N, input, 1: reset, asynchronous, active-low.
- SW, input, [3:1]: switch setting from the controller.
- DA, input, [1:0]: train A drive. 2'b01 is forward; any other value is stop.
- DB, input, [1:0]: train B drive, same encoding as DA.
- SR, output, [4:1]: sensors.
  - SR[1]: A at approach.
  - SR[2]: B at approach.
  - SR[3]: A at exit.
  - SR[4]: B at exit.
- POS_A, output, clog2(LOOP_LEN): train A position.
- POS_B, output, clog2(LOOP_LEN): train B position.
- DERAIL, output, [1:0]: sticky derail flags. Bit 0 is A, bit 1 is B.
- CRASH, output, 1: sticky collision flag.

## Operation
Reset values: POS_A = A_INIT, POS_B = B_INIT, prescaler = 0, DERAIL = 0, CRASH = 0, both trains in state RUN. SR is decoded from the reset positions.

Prescaler:
- Counts 0..STEP_DIV-1 and wraps.
- `tick` is high in the cycle where count == STEP_DIV-1.
- All train updates happen only on the rising edge where `tick` is high.

Per-train FSM:
- States are RUN, HOLD and FAULT.
- On a tick, a train not in FAULT goes to RUN if its D == 2'b01, otherwise to HOLD.
- FAULT is absorbing until reset.

Movement:
- In RUN, next position = (pos+1) mod LOOP_LEN.
- The position wraps from LOOP_LEN-1 to 0.
- HOLD and FAULT keep the position.

Route rule:
- Train A needs SW == 3'b000; train B needs SW == 3'b011.
- On a tick, a train derails if its candidate next position is in [COM_START, COM_END] and SW does not match its route.
- A derailing train does not move. Its DERAIL bit is set and it enters FAULT.
- This rule also applies to a stopped train sitting inside the common segment when SW changes to the wrong route.

Collision rule:
- After a tick's updates, if both positions are in [COM_START, COM_END], CRASH is set and both trains enter FAULT.
- If both trains enter on the same tick, this is a crash. Any derail detected on that tick takes precedence for the derailed train, because that train never moved.

Sensor decode (combinational from the position registers, level-sensitive):
- SR[1] = (POS_A == COM_START-1)
- SR[2] = (POS_B == COM_START-1)
- SR[3] = (POS_A == COM_END+1)
- SR[4] = (POS_B == COM_END+1)

Faults:
- DERAIL and CRASH are sticky and clear only on RESET_N low.
- After any fault, SR continues to reflect the frozen positions.

## Timing
- SW, DA and DB are sampled only on tick edges. Changes between ticks have no effect.
- After a moving tick edge, POS and SR change in the same cycle. There is no extra sensor latency.
- The first tick occurs on the STEP_DIV-th rising edge after RESET_N deasserts.
- Asserting RESET_N mid-operation immediately forces all reset values, including clearing the prescaler.
- With STEP_DIV = 1, every edge is a tick.

## Structure
- Shared package `track_pkg` holds:
  - ROUTE_A = 3'b000 and ROUTE_B = 3'b011
  - DIR_FWD = 2'b01 and DIR_STOP = 2'b00
  - the train state encoding (RUN, HOLD, FAULT)
  - the sensor index constants
- Sub-module `train_pos` contains one train's position register, FSM, derail check and sensor pair. It is instantiated twice with different route and init values.
- The top level holds the prescaler, the collision check and the flag muxing.

## Test plan
- Reset with defaults, DA = 01, DB = 00, SW = 000 → after 3 ticks (12 clocks) POS_A = 3 and SR = 4'b0001; POS_B stays at 8 and no flags are set.
- Continue from the previous scenario with SW = 000 → A passes positions 4–7; at POS_A = 8 SR[3] = 1; at the 16th tick POS_A wraps to 0.
- Train A at position 3, SW = 011, DA = 01 → on the next tick DERAIL = 2'b01 and POS_A stays at 3; later DA and SW changes do not move A.
- Place both trains at 3 (A_INIT = B_INIT = 3), SW = 000, DA = DB = 01 → B derails (DERAIL = 2'b10) and A enters position 4; CRASH = 0.
- A_INIT = 4, B_INIT = 3, SW toggled so B's route matches on B's entry tick, DA = 00, DB = 01 → A derails because its occupied segment is mis-routed, and CRASH = 1 at POS_B = 4. This exercises simultaneous fault handling.
- Drop RESET_N for one clock, mid-prescaler and with faults set → all flags clear, positions return to their init values, and the next tick arrives STEP_DIV edges after release.
